// File: rtl/sram_model_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_model_pkg : shared types and helpers for the 1RW+1R SRAM model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sram_model_pkg;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    READY_WAIT = 2'd1,
    READY      = 2'd2
  } sram_state_e;

  // Lanes are zero-extended to this width before parity is taken.
  localparam int MAX_LANE_W = 256;

  function automatic int lane_width(input int data_w, input int mask_w);
    return data_w / mask_w;
  endfunction

  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_rd_pipe : read-return pipeline, 1 or 2 cycles, dout holds value  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_perr,
  input  logic                  in_coll,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  perr,
  output logic                  coll
);

  logic                  mid_valid;
  logic [DATA_WIDTH-1:0] mid_data;
  logic                  mid_perr;
  logic                  mid_coll;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk0) begin
        if (rst0) begin
          mid_valid <= 1'b0;
          mid_data  <= '0;
          mid_perr  <= 1'b0;
          mid_coll  <= 1'b0;
        end else begin
          mid_valid <= in_valid;
          mid_data  <= in_data;
          mid_perr  <= in_perr;
          mid_coll  <= in_coll;
        end
      end
    end else begin : g_lat1
      always_comb begin
        mid_valid = in_valid;
        mid_data  = in_data;
        mid_perr  = in_perr;
        mid_coll  = in_coll;
      end
    end
  endgenerate

  // Flags are pulses qualified by valid; data only moves on a valid return.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rvalid <= 1'b0;
      dout   <= '0;
      perr   <= 1'b0;
      coll   <= 1'b0;
    end else begin
      rvalid <= mid_valid;
      perr   <= mid_valid & mid_perr;
      coll   <= mid_valid & mid_coll;
      if (mid_valid) dout <= mid_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_1rw1r_wmask_model.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_1rw1r_wmask_model : 1RW+1R SRAM model with lane mask, clear      |
// | sweep and optional lane parity (SRAM_PARITY_EN).  Rev 1.0             |
// +----------------------------------------------------------------------+
module sram_1rw1r_wmask_model
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  output logic                   ready,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   rvalid0,
  output logic                   perr0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   rvalid1,
  output logic                   perr1,
  output logic                   coll1
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = lane_width(DATA_WIDTH, WMASK_WIDTH);
`ifdef SRAM_PARITY_EN
  localparam int STORE_W   = DATA_WIDTH + WMASK_WIDTH;
`else
  localparam int STORE_W   = DATA_WIDTH;
`endif

  logic [STORE_W-1:0]    mem [RAM_DEPTH];
  sram_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  wr_acc, rd0_acc, rd1_acc, coll_now;
  logic [STORE_W-1:0]    wr_word, rd0_word, rd1_word;
  logic                  perr0_raw, perr1_raw;

  assign ready = (state == READY);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY_WAIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:      if (&clr_cnt) state_nxt = READY;
      READY_WAIT: state_nxt = READY;
      default:    state_nxt = state;
    endcase
  end

  always_comb begin
    wr_acc   = ready & ~rst0 & ~csb0 & ~web0;
    rd0_acc  = ready & ~rst0 & ~csb0 & web0;
    rd1_acc  = ready & ~rst0 & ~csb1;
    coll_now = wr_acc & (addr1 == addr0);
    rd0_word = mem[addr0];
    rd1_word = mem[addr1];
  end

  always_comb begin
    wr_word = mem[addr0];
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (wmask0[i]) begin
        wr_word[i*LANE_W +: LANE_W] = din0[i*LANE_W +: LANE_W];
`ifdef SRAM_PARITY_EN
        wr_word[DATA_WIDTH+i] = lane_parity(MAX_LANE_W'(din0[i*LANE_W +: LANE_W]));
`endif
      end
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk0) begin
    if (!rst0 && state == CLEAR) mem[clr_cnt] <= '0;
    else if (wr_acc)             mem[addr0]   <= wr_word;
  end

`ifdef SRAM_PARITY_EN
  always_comb begin
    perr0_raw = 1'b0;
    perr1_raw = 1'b0;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      perr0_raw |= lane_parity(MAX_LANE_W'(rd0_word[i*LANE_W +: LANE_W])) ^ rd0_word[DATA_WIDTH+i];
      perr1_raw |= lane_parity(MAX_LANE_W'(rd1_word[i*LANE_W +: LANE_W])) ^ rd1_word[DATA_WIDTH+i];
    end
  end

  task automatic inject_parity_flip(input logic [ADDR_WIDTH-1:0] addr, input int lane);
    mem[addr][DATA_WIDTH+lane] = ~mem[addr][DATA_WIDTH+lane];
  endtask
`else
  always_comb begin
    perr0_raw = 1'b0;
    perr1_raw = 1'b0;
  end
`endif

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe0 (
    .clk0     (clk0),
    .rst0     (rst0),
    .in_valid (rd0_acc),
    .in_data  (rd0_word[DATA_WIDTH-1:0]),
    .in_perr  (perr0_raw),
    .in_coll  (1'b0),
    .rvalid   (rvalid0),
    .dout     (dout0),
    .perr     (perr0),
    .coll     ()
  );

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe1 (
    .clk0     (clk0),
    .rst0     (rst0),
    .in_valid (rd1_acc),
    .in_data  (rd1_word[DATA_WIDTH-1:0]),
    .in_perr  (perr1_raw),
    .in_coll  (coll_now),
    .rvalid   (rvalid1),
    .dout     (dout1),
    .perr     (perr1),
    .coll     (coll1)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_wmask_model.sv
`default_nettype none
// Bench: latency-1 and latency-2 instances share stimulus; both are checked every cycle
// against an array-based reference model plus directed constant checks.
module tb_sram_1rw1r_wmask_model;

  localparam int DW = 32, AW = 4, MW = 4, LW = 8, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, csb0, web0, csb1;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  logic          ready [2], rvalid0 [2], perr0 [2], rvalid1 [2], perr1 [2], coll1 [2];
  logic [DW-1:0] dout0 [2], dout1 [2];

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
                           .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
    .clk0(clk), .rst0(rst), .ready(ready[0]), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0[0]), .rvalid0(rvalid0[0]), .perr0(perr0[0]),
    .csb1(csb1), .addr1(addr1), .dout1(dout1[0]), .rvalid1(rvalid1[0]), .perr1(perr1[0]),
    .coll1(coll1[0]));

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
                           .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
    .clk0(clk), .rst0(rst), .ready(ready[1]), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0[1]), .rvalid0(rvalid0[1]), .perr0(perr0[1]),
    .csb1(csb1), .addr1(addr1), .dout1(dout1[1]), .rvalid1(rvalid1[1]), .perr1(perr1[1]),
    .coll1(coll1[1]));

  // Reference model: word array, flipped-parity lanes, and per-edge read history.
  logic [DW-1:0] mem_m [DEPTH];
  logic [MW-1:0] flip_m [DEPTH];
  int            since_rel;
  bit            m_ready;
  int            n;
  bit            hv0 [64], hv1 [64], hc1 [64], hp0 [64], hp1 [64];
  logic [DW-1:0] hd0 [64], hd1 [64];
  logic [DW-1:0] exp_d0 [2], exp_d1 [2];

  int checks, failures;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic tick();
    bit acc;
    bit ev0, ev1;
    int idx;
    @(posedge clk);
    n++;
    acc = m_ready && !rst;
    hv0[n%64] = acc && !csb0 && web0;
    hd0[n%64] = mem_m[addr0];
    hp0[n%64] = (flip_m[addr0] != 0);
    hv1[n%64] = acc && !csb1;
    hd1[n%64] = mem_m[addr1];
    hp1[n%64] = (flip_m[addr1] != 0);
    hc1[n%64] = acc && !csb1 && !csb0 && !web0 && (addr0 == addr1);
    if (acc && !csb0 && !web0)
      for (int i = 0; i < MW; i++)
        if (wmask0[i]) begin
          mem_m[addr0][i*LW +: LW] = din0[i*LW +: LW];
          flip_m[addr0][i] = 1'b0;
        end
    if (rst) begin
      since_rel = 0;
      m_ready   = 0;
      for (int j = 0; j < 64; j++) begin hv0[j] = 0; hv1[j] = 0; end
      for (int k = 0; k < 2; k++) begin exp_d0[k] = '0; exp_d1[k] = '0; end
    end else if (since_rel < DEPTH) begin
      since_rel++;
      if (since_rel == DEPTH) begin
        m_ready = 1;
        for (int a = 0; a < DEPTH; a++) begin mem_m[a] = '0; flip_m[a] = '0; end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      idx = n - k;
      ev0 = (idx >= 1) && hv0[idx%64];
      ev1 = (idx >= 1) && hv1[idx%64];
      if (ev0) exp_d0[k] = hd0[idx%64];
      if (ev1) exp_d1[k] = hd1[idx%64];
      check_eq($sformatf("ready_L%0d", k+1),   ready[k],   m_ready);
      check_eq($sformatf("rvalid0_L%0d", k+1), rvalid0[k], ev0);
      check_eq($sformatf("dout0_L%0d", k+1),   dout0[k],   exp_d0[k]);
      check_eq($sformatf("perr0_L%0d", k+1),   perr0[k],   ev0 && hp0[idx%64]);
      check_eq($sformatf("rvalid1_L%0d", k+1), rvalid1[k], ev1);
      check_eq($sformatf("dout1_L%0d", k+1),   dout1[k],   exp_d1[k]);
      check_eq($sformatf("perr1_L%0d", k+1),   perr1[k],   ev1 && hp1[idx%64]);
      check_eq($sformatf("coll1_L%0d", k+1),   coll1[k],   ev1 && hc1[idx%64]);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic wait_ready(input int exp_cycles);
    int c;
    c = 0;
    while (ready[0] !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check_eq("ready_latency", c, exp_cycles);
  endtask

  initial begin
    int cnt0, cnt1;
    checks = 0; failures = 0; n = 0; since_rel = 0; m_ready = 0;
    for (int j = 0; j < 64; j++) begin hv0[j] = 0; hv1[j] = 0; hc1[j] = 0; hp0[j] = 0; hp1[j] = 0; end
    for (int a = 0; a < DEPTH; a++) begin mem_m[a] = '0; flip_m[a] = '0; end
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_ready(16);

    // All addresses read back as zero after the sweep.
    for (int a = 0; a < DEPTH; a++) begin
      rd0(AW'(a)); csb1 = 1'b0; addr1 = AW'(DEPTH-1-a);
      tick();
    end
    idle(); repeat (2) tick();

    // Masked write merge.
    wr(4'd3, 32'hDEADBEEF, 4'b1111); tick();
    wr(4'd3, 32'h11223344, 4'b0101); tick();
    idle(); rd0(4'd3); tick();
    check_eq("masked_word_L1", dout0[0], 32'hDE22BE44);
    idle(); tick();
    check_eq("masked_word_L2", dout0[1], 32'hDE22BE44);

    // Same-address write/read collision returns the old word.
    wr(4'd5, 32'hAAAA5555, 4'b1111); tick();
    wr(4'd5, 32'h12345678, 4'b1111); csb1 = 1'b0; addr1 = 4'd5; tick();
    check_eq("coll_old_data", dout1[0], 32'hAAAA5555);
    check_eq("coll_flag", coll1[0], 1'b1);
    csb0 = 1'b1; tick();
    check_eq("post_coll_data", dout1[0], 32'h12345678);
    check_eq("post_coll_flag", coll1[0], 1'b0);
    idle(); repeat (2) tick();

    // Back-to-back dual-port reads; count latency-2 returns.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      rd0(AW'($urandom_range(0, DEPTH-1)));
      csb1 = 1'b0; addr1 = AW'($urandom_range(0, DEPTH-1));
      tick();
      cnt0 += int'(rvalid0[1]); cnt1 += int'(rvalid1[1]);
    end
    idle();
    repeat (3) begin
      tick();
      cnt0 += int'(rvalid0[1]); cnt1 += int'(rvalid1[1]);
    end
    check_eq("b2b_rvalid0_count", cnt0, 16);
    check_eq("b2b_rvalid1_count", cnt1, 16);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1) != 0;
      wmask0 = MW'($urandom);
      addr0  = AW'($urandom);
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = ($urandom_range(0, 3) == 0) ? addr0 : AW'($urandom);
      tick();
    end
    idle(); repeat (3) tick();

    // Requests during the clear sweep are dropped; a mid-sweep reset restarts it.
    wr(4'd2, 32'h5A5A5A5A, 4'b1111); tick();
    idle(); repeat (2) tick();
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0;
    repeat (3) begin
      wr(4'd2, 32'hFFFFFFFF, 4'b1111); csb1 = 1'b0; addr1 = 4'd2;
      tick();
    end
    idle(); repeat (5) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    wait_ready(16);
    rd0(4'd2); tick();
    check_eq("clear_drop_word", dout0[0], 32'h0);
    idle(); repeat (2) tick();

`ifdef SRAM_PARITY_EN
    wr(4'd7, 32'h0F0F0F0F, 4'b1111); tick();
    idle(); tick();
    dut_l1.inject_parity_flip(4'd7, 2);
    dut_l2.inject_parity_flip(4'd7, 2);
    flip_m[7][2] = 1'b1;
    rd0(4'd7); tick();
    check_eq("perr_flipped", perr0[0], 1'b1);
    rd0(4'd6); tick();
    check_eq("perr_clean", perr0[0], 1'b0);
`else
    wr(4'd7, 32'h0F0F0F0F, 4'b1111); tick();
    rd0(4'd7); tick();
    check_eq("perr_disabled", perr0[0], 1'b0);
`endif
    idle(); repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
